// File: rtl/backup_sd_ctrl.sv
// rtl/backup_sd_ctrl.sv - backup RAM <-> SD image sector sequencer with format, autosave and ack timeout
//
// Ports:
//   clk_sys, reset           clock, async active-high reset
//   bk_ena                   save image mounted and writable
//   load_req/save_req        level requests, rising edge starts a load/save job
//   format_req               level request, rising edge starts (or queues) a header format
//   mount_load, img_nonzero  end-of-download pulse, qualified by a non-empty image -> auto-load
//   slot                     slot index, captured at job start
//   autosave_en, bram_wr     autosave enable, core write strobe to backup RAM
//   sd_ack                   hps_io sector acknowledge
//   sd_lba, sd_rd, sd_wr     sector address and read/write requests to hps_io
//   fmt_we/fmt_addr/fmt_data header word write port (port-B mux select while fmt_we=1)
//   bk_loading, bk_busy      load job active (core held in reset), any job active
//   done, err                job-complete pulse, sticky abort flag
module backup_sd_ctrl #(
  parameter int SECTOR_W = 4,
  parameter int SLOT_W = 2,
  parameter int FMT_WORDS = 4,
  parameter logic [16*FMT_WORDS-1:0] FMT_INIT = 64'h8010_8800_4D42_5548,
  parameter logic [23:0] AUTO_CYC = 24'd5000000,
  parameter logic [23:0] TIMEOUT = 24'hFFFFFF,
  localparam int FA_W = (FMT_WORDS > 1) ? $clog2(FMT_WORDS) : 1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              bk_ena,
  input  logic              load_req,
  input  logic              save_req,
  input  logic              format_req,
  input  logic              mount_load,
  input  logic              img_nonzero,
  input  logic [SLOT_W-1:0] slot,
  input  logic              autosave_en,
  input  logic              bram_wr,
  input  logic              sd_ack,
  output logic [31:0]       sd_lba,
  output logic              sd_rd,
  output logic              sd_wr,
  output logic              fmt_we,
  output logic [FA_W-1:0]   fmt_addr,
  output logic [15:0]       fmt_data,
  output logic              bk_loading,
  output logic              bk_busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, REQ, XFER, FMT} state_t;

  state_t                state;
  logic                  load_d, save_d, fmt_d, ack_d;
  logic                  dirty, fmt_pend;
  logic [23:0]           cnt, idle_cnt;
  logic [SECTOR_W-1:0]   sector;
  logic [SLOT_W-1:0]     slot_q;

  logic load_edge, save_edge, fmt_edge, ack_rise, ack_fall;
  logic do_load, do_save, do_auto, start_xfer, do_fmt;
  logic [FA_W-1:0] fmt_next;

  assign load_edge  = load_req & ~load_d;
  assign save_edge  = save_req & ~save_d;
  assign fmt_edge   = format_req & ~fmt_d;
  assign ack_rise   = sd_ack & ~ack_d;
  assign ack_fall   = ~sd_ack & ack_d;

  assign do_load    = (load_edge | (mount_load & img_nonzero)) & bk_ena;
  assign do_save    = save_edge & bk_ena;
  assign do_auto    = autosave_en & bk_ena & dirty & (idle_cnt >= AUTO_CYC);
  assign start_xfer = (state == IDLE) & (do_load | do_save | do_auto);
  // A queued format only runs when no transfer wants to start this cycle.
  assign do_fmt     = (state == IDLE) & ~start_xfer & (fmt_edge | fmt_pend);
  assign fmt_next   = fmt_addr + FA_W'(1);

  assign sd_lba     = 32'({slot_q, sector});

  // Dirty tracking and idle timer feeding autosave. A save start clears
  // dirty, but a write landing in that same cycle keeps it set.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dirty    <= 1'b0;
      idle_cnt <= '0;
    end else begin
      if (start_xfer & ~do_load)
        dirty <= bram_wr;
      else if (bram_wr)
        dirty <= 1'b1;

      if (bram_wr | ~autosave_en | start_xfer)
        idle_cnt <= '0;
      else if (dirty & (state == IDLE) & (idle_cnt != 24'hFFFFFF))
        idle_cnt <= idle_cnt + 24'd1;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      load_d     <= 1'b0;
      save_d     <= 1'b0;
      fmt_d      <= 1'b0;
      ack_d      <= 1'b0;
      fmt_pend   <= 1'b0;
      cnt        <= '0;
      sector     <= '0;
      slot_q     <= '0;
      sd_rd      <= 1'b0;
      sd_wr      <= 1'b0;
      fmt_we     <= 1'b0;
      fmt_addr   <= '0;
      fmt_data   <= '0;
      bk_loading <= 1'b0;
      bk_busy    <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      load_d <= load_req;
      save_d <= save_req;
      fmt_d  <= format_req;
      ack_d  <= sd_ack;
      done   <= 1'b0;

      case (state)
        IDLE: begin
          if (start_xfer) begin
            slot_q     <= slot;
            sector     <= '0;
            err        <= 1'b0;
            sd_rd      <= do_load;
            sd_wr      <= ~do_load;
            bk_loading <= do_load;
            bk_busy    <= 1'b1;
            cnt        <= '0;
            state      <= REQ;
            if (fmt_edge) fmt_pend <= 1'b1;
          end else if (do_fmt) begin
            err      <= 1'b0;
            fmt_pend <= 1'b0;
            fmt_we   <= 1'b1;
            fmt_addr <= '0;
            fmt_data <= FMT_INIT[15:0];
            bk_busy  <= 1'b1;
            state    <= FMT;
          end
        end

        REQ: begin
          if (fmt_edge) fmt_pend <= 1'b1;
          if (ack_rise) begin
            sd_rd <= 1'b0;
            sd_wr <= 1'b0;
            state <= XFER;
          end else if (cnt == TIMEOUT) begin
            sd_rd      <= 1'b0;
            sd_wr      <= 1'b0;
            err        <= 1'b1;
            bk_loading <= 1'b0;
            bk_busy    <= 1'b0;
            state      <= IDLE;
          end else begin
            cnt <= cnt + 24'd1;
          end
        end

        XFER: begin
          if (fmt_edge) fmt_pend <= 1'b1;
          if (ack_fall) begin
            if (&sector) begin
              done       <= 1'b1;
              bk_loading <= 1'b0;
              bk_busy    <= 1'b0;
              sector     <= '0;
              state      <= IDLE;
            end else if (!bk_ena) begin
              // Image vanished between sectors: abort like a timeout.
              err        <= 1'b1;
              bk_loading <= 1'b0;
              bk_busy    <= 1'b0;
              state      <= IDLE;
            end else begin
              // sector and rd/wr change on the same edge so lba is valid with the request.
              sector <= sector + SECTOR_W'(1);
              sd_rd  <= bk_loading;
              sd_wr  <= ~bk_loading;
              cnt    <= '0;
              state  <= REQ;
            end
          end
        end

        FMT: begin
          if (fmt_addr == FA_W'(FMT_WORDS - 1)) begin
            fmt_we   <= 1'b0;
            fmt_addr <= '0;
            done     <= 1'b1;
            bk_busy  <= 1'b0;
            state    <= IDLE;
          end else begin
            fmt_addr <= fmt_next;
            fmt_data <= FMT_INIT[16*int'(fmt_next) +: 16];
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_backup_sd_ctrl.sv
// tb/tb_backup_sd_ctrl.sv - scoreboard bench for backup_sd_ctrl
module tb_backup_sd_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        bk_ena = 1'b1;
  logic        load_req = 1'b0, save_req = 1'b0, format_req = 1'b0;
  logic        mount_load = 1'b0, img_nonzero = 1'b0;
  logic [1:0]  slot = 2'd0;
  logic        autosave_en = 1'b0, bram_wr = 1'b0, sd_ack = 1'b0;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, fmt_we, bk_loading, bk_busy, done, err;
  logic [1:0]  fmt_addr;
  logic [15:0] fmt_data;

  always #5 clk_sys = ~clk_sys;

  backup_sd_ctrl #(
    .AUTO_CYC(24'd100),
    .TIMEOUT (24'd64)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .bk_ena     (bk_ena),
    .load_req   (load_req),
    .save_req   (save_req),
    .format_req (format_req),
    .mount_load (mount_load),
    .img_nonzero(img_nonzero),
    .slot       (slot),
    .autosave_en(autosave_en),
    .bram_wr    (bram_wr),
    .sd_ack     (sd_ack),
    .sd_lba     (sd_lba),
    .sd_rd      (sd_rd),
    .sd_wr      (sd_wr),
    .fmt_we     (fmt_we),
    .fmt_addr   (fmt_addr),
    .fmt_data   (fmt_data),
    .bk_loading (bk_loading),
    .bk_busy    (bk_busy),
    .done       (done),
    .err        (err)
  );

  typedef struct packed {logic wr; logic [31:0] lba;} req_t;
  typedef struct packed {logic [1:0] addr; logic [15:0] data; int cyc;} fmt_t;

  req_t exp_q[$];
  req_t obs_q[$];
  fmt_t fmt_obs[$];
  int   checks = 0, errors = 0;
  int   done_cnt = 0, cyc = 0, loading_seen = 0, busy_not_loading = 0;
  logic req_prev = 1'b0;
  bit   ack_en = 1'b1;
  logic [63:0] init_v = 64'h8010_8800_4D42_5548;

  // Monitor: records each new request, format writes, done pulses.
  always @(negedge clk_sys) begin
    req_t r;
    fmt_t f;
    cyc++;
    if ((sd_rd | sd_wr) && !req_prev) begin
      r.wr = sd_wr;
      r.lba = sd_lba;
      obs_q.push_back(r);
    end
    req_prev = sd_rd | sd_wr;
    if (done) done_cnt++;
    if (bk_loading) loading_seen++;
    if (bk_busy && !bk_loading) busy_not_loading++;
    if (fmt_we) begin
      f.addr = fmt_addr;
      f.data = fmt_data;
      f.cyc = cyc;
      fmt_obs.push_back(f);
    end
  end

  // hps_io ack model: 20 cycles after a request, ack until rd/wr drop, then release.
  initial begin
    forever begin
      @(posedge clk_sys); #1;
      if (ack_en && (sd_rd || sd_wr) && !reset) begin
        repeat (19) @(posedge clk_sys);
        #1 sd_ack = 1'b1;
        for (int k = 0; k < 100 && (sd_rd || sd_wr); k++) begin
          @(posedge clk_sys); #1;
        end
        repeat (2) @(posedge clk_sys);
        #1 sd_ack = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_done(input int target, input int max_cyc, output bit ok);
    ok = 0;
    for (int k = 0; k < max_cyc; k++) begin
      @(posedge clk_sys); #1;
      if (done_cnt >= target) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    tick(3);
    checks++;
    if ({sd_rd, sd_wr, fmt_we, bk_loading, bk_busy, done, err, sd_lba, fmt_addr, fmt_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rd=%b wr=%b we=%b ld=%b busy=%b done=%b err=%b lba=%h, want all 0",
               sd_rd, sd_wr, fmt_we, bk_loading, bk_busy, done, err, sd_lba);
    end
    reset = 1'b0;
    tick(2);
    checks++;
    if (bk_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: bk_busy=%b want 0", bk_busy);
    end
  endtask

  task automatic test_save;
    bit ok;
    obs_q.delete(); exp_q.delete();
    done_cnt = 0; loading_seen = 0;
    slot = 2'd2;
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, 32'h20 + 32'(i)});
    save_req = 1'b1;
    wait_done(1, 3000, ok);
    tick(3);
    checks++;
    if (!ok) begin errors++; $display("FAIL save_done_timeout: no done within 3000 cycles"); end
    checks++;
    if (obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL save_count: got %0d requests want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      req_t e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL save_req: got wr=%b lba=%h want wr=%b lba=%h", o.wr, o.lba, e.wr, e.lba);
      end
    end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL save_done_count: got %0d want 1", done_cnt); end
    checks++;
    if (loading_seen !== 0) begin errors++; $display("FAIL save_loading: bk_loading high %0d cycles want 0", loading_seen); end
    checks++;
    if ({err, bk_busy} !== 2'b00) begin errors++; $display("FAIL save_end: err=%b busy=%b want 0 0", err, bk_busy); end
    save_req = 1'b0;
    tick(2);
  endtask

  task automatic test_load;
    bit ok;
    obs_q.delete(); exp_q.delete();
    done_cnt = 0; busy_not_loading = 0;
    slot = 2'd0;
    img_nonzero = 1'b1;
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b0, 32'(i)});
    mount_load = 1'b1;
    tick(1);
    mount_load = 1'b0;
    wait_done(1, 3000, ok);
    tick(3);
    checks++;
    if (!ok) begin errors++; $display("FAIL load_done_timeout: no done within 3000 cycles"); end
    checks++;
    if (obs_q.size() !== 16) begin errors++; $display("FAIL load_count: got %0d requests want 16", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      req_t e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL load_req: got wr=%b lba=%h want wr=%b lba=%h", o.wr, o.lba, e.wr, e.lba);
      end
    end
    checks++;
    if (busy_not_loading !== 0) begin errors++; $display("FAIL load_loading: busy without loading %0d cycles want 0", busy_not_loading); end
    checks++;
    if ({bk_loading, bk_busy, done_cnt} !== {2'b00, 32'd1}) begin
      errors++;
      $display("FAIL load_end: loading=%b busy=%b dones=%0d want 0 0 1", bk_loading, bk_busy, done_cnt);
    end
  endtask

  task automatic test_format;
    bit ok;
    fmt_obs.delete();
    done_cnt = 0;
    format_req = 1'b1;
    wait_done(1, 100, ok);
    tick(2);
    checks++;
    if (!ok) begin errors++; $display("FAIL fmt_done_timeout: no done within 100 cycles"); end
    checks++;
    if (fmt_obs.size() !== 4) begin errors++; $display("FAIL fmt_count: got %0d writes want 4", fmt_obs.size()); end
    for (int i = 0; i < 4 && i < fmt_obs.size(); i++) begin
      checks++;
      if (fmt_obs[i].addr !== 2'(i) || fmt_obs[i].data !== init_v[16*i +: 16] || fmt_obs[i].cyc !== fmt_obs[0].cyc + i) begin
        errors++;
        $display("FAIL fmt_word%0d: got addr=%0d data=%h cyc+%0d want addr=%0d data=%h cyc+%0d",
                 i, fmt_obs[i].addr, fmt_obs[i].data, fmt_obs[i].cyc - fmt_obs[0].cyc, i, init_v[16*i +: 16], i);
      end
    end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL fmt_done_count: got %0d want 1", done_cnt); end
    format_req = 1'b0;
    tick(2);
  endtask

  task automatic test_disabled;
    obs_q.delete();
    bk_ena = 1'b0;
    save_req = 1'b1;
    tick(10);
    checks++;
    if ({bk_busy, err} !== 2'b00 || obs_q.size() !== 0) begin
      errors++;
      $display("FAIL disabled_save: busy=%b err=%b reqs=%0d want 0 0 0", bk_busy, err, obs_q.size());
    end
    save_req = 1'b0;
    bk_ena = 1'b1;
    tick(2);
  endtask

  task automatic test_autosave;
    bit ok;
    int n, n2;
    autosave_en = 1'b1;
    slot = 2'd1;
    obs_q.delete(); done_cnt = 0;
    bram_wr = 1'b1; tick(1); bram_wr = 1'b0;
    n = 0;
    while (!sd_wr && n < 400) begin tick(1); n++; end
    checks++;
    if (n < 100 || n > 102) begin errors++; $display("FAIL auto_delay: save after %0d cycles want 100..102", n); end
    wait_done(1, 3000, ok);
    tick(3);
    checks++;
    if (!ok || obs_q.size() !== 16 || obs_q[0] !== {1'b1, 32'h10}) begin
      errors++;
      $display("FAIL auto_job: done=%b reqs=%0d want done, 16 writes from lba 10", ok, obs_q.size());
    end
    obs_q.delete();
    bram_wr = 1'b1; tick(1); bram_wr = 1'b0;
    tick(49);
    bram_wr = 1'b1; tick(1); bram_wr = 1'b0;
    n2 = 0;
    while (!sd_wr && n2 < 400) begin tick(1); n2++; end
    checks++;
    if (n2 < 100 || n2 > 102 || obs_q.size() > 1) begin
      errors++;
      $display("FAIL auto_retrigger: save %0d cycles after 2nd write (%0d early reqs) want 100..102, 0", n2, obs_q.size());
    end
    done_cnt = 0;
    wait_done(1, 3000, ok);
    obs_q.delete();
    tick(200);
    checks++;
    if (obs_q.size() !== 0) begin errors++; $display("FAIL auto_clean: got %0d reqs after save want 0", obs_q.size()); end
    autosave_en = 1'b0;
  endtask

  task automatic test_timeout;
    bit ok;
    int n, w;
    ack_en = 0;
    done_cnt = 0;
    save_req = 1'b1;
    w = 0;
    while (!sd_wr && w < 20) begin tick(1); w++; end
    n = 0;
    while (sd_wr && n < 300) begin tick(1); n++; end
    tick(2);
    checks++;
    if (n < 64 || n > 65) begin errors++; $display("FAIL timeout_len: wr high %0d cycles want 64..65", n); end
    checks++;
    if ({err, bk_busy, done_cnt} !== {2'b10, 32'd0}) begin
      errors++;
      $display("FAIL timeout_state: err=%b busy=%b dones=%0d want 1 0 0", err, bk_busy, done_cnt);
    end
    save_req = 1'b0;
    tick(2);
    ack_en = 1;
    save_req = 1'b1;
    tick(3);
    checks++;
    if ({err, bk_busy} !== 2'b01) begin errors++; $display("FAIL timeout_clear: err=%b busy=%b want 0 1", err, bk_busy); end
    wait_done(1, 3000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL timeout_retry: no done within 3000 cycles"); end
    save_req = 1'b0;
    tick(2);
  endtask

  task automatic test_back_to_back;
    bit ok;
    done_cnt = 0;
    fmt_obs.delete();
    save_req = 1'b1;
    tick(30);
    format_req = 1'b1; tick(2); format_req = 1'b0; tick(2);
    format_req = 1'b1; tick(2); format_req = 1'b0;
    wait_done(2, 3000, ok);
    tick(20);
    checks++;
    if (!ok || done_cnt !== 2 || fmt_obs.size() !== 4) begin
      errors++;
      $display("FAIL fmt_pending: dones=%0d fmt writes=%0d want 2, 4", done_cnt, fmt_obs.size());
    end
    save_req = 1'b0;
    tick(2);
  endtask

  task automatic test_reset_midjob;
    int w;
    obs_q.delete();
    slot = 2'd0;
    load_req = 1'b1;
    w = 0;
    while (obs_q.size() < 6 && w < 2000) begin tick(1); w++; end
    checks++;
    if (obs_q.size() < 6 || obs_q[5] !== {1'b0, 32'd5}) begin
      errors++;
      $display("FAIL midjob_reach: got %0d reqs want sector 5 read", obs_q.size());
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({sd_rd, bk_loading, bk_busy} !== 3'b000) begin
      errors++;
      $display("FAIL midjob_reset: rd=%b loading=%b busy=%b want 0 0 0", sd_rd, bk_loading, bk_busy);
    end
    load_req = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(40);
    checks++;
    if ({sd_rd, sd_wr, bk_busy} !== 3'b000 || obs_q.size() !== 6) begin
      errors++;
      $display("FAIL midjob_idle: rd=%b wr=%b busy=%b reqs=%0d want 0 0 0 6", sd_rd, sd_wr, bk_busy, obs_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_save();
    test_load();
    test_format();
    test_disabled();
    test_autosave();
    test_timeout();
    test_back_to_back();
    test_reset_midjob();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
